// File: rtl/ahb_console_fifo.sv
// ============================================================================
// Module      : ahb_console_fifo
// Description : AHB-Lite console slave with a byte TX FIFO drained over a
//               valid/ready stream, status/control, sticky exit request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_console_fifo #(
   parameter int ADDR_WIDTH  = 12,
   parameter int FIFO_AW     = 4,
   parameter int WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADY,
   output logic [31:0]           HRDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic                  tty_valid,
   output logic [7:0]            tty_data,
   input  logic                  tty_ready,
   output logic                  stop_req,
   output logic [7:0]            stop_code
);

   localparam int              c_DEPTH      = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] c_FULL_LEVEL = {1'b1, {FIFO_AW{1'b0}}};
   localparam bit              c_HAS_WAIT   = (WAIT_STATES > 0);
   localparam logic [3:0]      c_WAIT_LAST  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   localparam logic [1:0] c_OFS_DATA   = 2'd0;
   localparam logic [1:0] c_OFS_STATUS = 2'd1;
   localparam logic [1:0] c_OFS_CTRL   = 2'd2;
   localparam logic [1:0] c_OFS_EXIT   = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_STALL = 3'd2,
      S_ERR1  = 3'd3,
      S_ERR2  = 3'd4
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic             r_dp_valid;
   logic             r_dp_write;
   logic [1:0]       r_dp_offset;
   logic [3:0]       r_wait_cnt;
   logic [FIFO_AW:0] r_wr_ptr;
   logic [FIFO_AW:0] r_rd_ptr;
   logic             r_ovf;
   logic             r_drop;
   logic             r_stop_req;
   logic [7:0]       r_stop_code;
   logic [7:0]       r_mem [c_DEPTH];

   logic [FIFO_AW:0] w_level;
   logic [7:0]       w_level_8;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_accept;
   logic             w_addr_ok;
   logic             w_active;
   logic             w_data_wr;
   logic             w_blocked;
   logic             w_do;
   logic             w_push;
   logic             w_drop_hit;
   logic             w_take;
   logic             w_unused_bits;

   assign w_level   = r_wr_ptr - r_rd_ptr;
   assign w_level_8 = 8'(w_level);
   assign w_full    = (w_level == c_FULL_LEVEL);
   assign w_empty   = (w_level == '0);
   assign w_pop     = !w_empty && tty_ready;

   assign w_accept  = HSEL && HREADY && HTRANS[1];
   assign w_addr_ok = ~|HADDR[ADDR_WIDTH-1:4];

   // A latched data phase executes in IDLE (after any wait states) or retries in STALL.
   assign w_active   = r_dp_valid && ((r_state == S_IDLE) || (r_state == S_STALL));
   assign w_data_wr  = w_active && r_dp_write && (r_dp_offset == c_OFS_DATA);
   assign w_blocked  = w_data_wr && w_full && !w_pop && !r_drop;
   assign w_do       = w_active && !w_blocked;
   assign w_push     = w_data_wr && !w_blocked && (!w_full || w_pop);
   assign w_drop_hit = w_data_wr && w_full && !w_pop && r_drop;

   assign tty_valid = !w_empty;
   assign tty_data  = r_mem[r_rd_ptr[FIFO_AW-1:0]];
   assign stop_req  = r_stop_req;
   assign stop_code = r_stop_code;

   assign w_unused_bits = ^{HSIZE, HADDR[1:0], HTRANS[0], HWDATA[31:10], HWDATA[8]};

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      HREADYOUT    = 1'b1;
      HRESP        = 1'b0;
      w_take       = 1'b0;
      case (r_state)
         S_IDLE, S_STALL: begin
            if (w_blocked) begin
               HREADYOUT    = 1'b0;
               w_state_next = S_STALL;
            end else begin
               w_take = 1'b1;
            end
         end
         S_WAIT: begin
            HREADYOUT = 1'b0;
            if (r_wait_cnt == c_WAIT_LAST) begin
               w_state_next = S_IDLE;
            end
         end
         S_ERR1: begin
            HREADYOUT    = 1'b0;
            HRESP        = 1'b1;
            w_state_next = S_ERR2;
         end
         S_ERR2: begin
            HRESP  = 1'b1;
            w_take = 1'b1;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      // Any cycle with HREADYOUT high may start the next transfer.
      if (w_take) begin
         if (w_accept && !w_addr_ok) begin
            w_state_next = S_ERR1;
         end else if (w_accept && c_HAS_WAIT) begin
            w_state_next = S_WAIT;
         end else begin
            w_state_next = S_IDLE;
         end
      end
   end

   always_comb begin
      HRDATA = 32'd0;
      if (w_do && !r_dp_write) begin
         case (r_dp_offset)
            c_OFS_STATUS: HRDATA = {22'd0, r_ovf, w_full, w_level_8};
            c_OFS_CTRL:   HRDATA = {31'd0, r_drop};
            c_OFS_EXIT:   HRDATA = {24'd0, r_stop_code};
            default:      HRDATA = 32'd0;
         endcase
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_dp_valid  <= 1'b0;
         r_dp_write  <= 1'b0;
         r_dp_offset <= 2'd0;
         r_wait_cnt  <= 4'd0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_ovf       <= 1'b0;
         r_drop      <= 1'b0;
         r_stop_req  <= 1'b0;
         r_stop_code <= 8'd0;
      end else begin
         if (w_take) begin
            r_dp_valid  <= w_accept && w_addr_ok;
            r_dp_write  <= HWRITE;
            r_dp_offset <= HADDR[3:2];
         end
         r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 4'd1 : 4'd0;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_drop_hit) begin
            r_ovf <= 1'b1;
         end
         if (w_do && r_dp_write) begin
            case (r_dp_offset)
               c_OFS_STATUS: if (HWDATA[9]) r_ovf <= 1'b0;
               c_OFS_CTRL:   r_drop <= HWDATA[0];
               c_OFS_EXIT: begin
                  r_stop_req  <= 1'b1;
                  r_stop_code <= HWDATA[7:0];
               end
               default: ;
            endcase
         end
      end
   end

   // Storage needs no reset: contents are only visible through the pointers.
   always_ff @(posedge HCLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr[FIFO_AW-1:0]] <= HWDATA[7:0];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ahb_console_fifo.sv
// ============================================================================
// Module      : tb_ahb_console_fifo
// Description : Self-checking bench for ahb_console_fifo; stream bytes are
//               checked against a queue of expected bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_console_fifo;

   localparam logic [11:0] c_A_DATA   = 12'h000;
   localparam logic [11:0] c_A_STATUS = 12'h004;
   localparam logic [11:0] c_A_CTRL   = 12'h008;
   localparam logic [11:0] c_A_EXIT   = 12'h00C;

   logic        sim_clock = 1'b0;
   logic        power_on_reset_n;
   logic        hsel0, hsel1;
   logic [11:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        tty_ready;

   logic [31:0] hrdata0, hrdata1;
   logic        hreadyout0, hreadyout1;
   logic        hresp0, hresp1;
   logic        tty_valid0, tty_valid1;
   logic [7:0]  tty_data0, tty_data1;
   logic        stop_req0, stop_req1;
   logic [7:0]  stop_code0, stop_code1;

   int          n_compared   = 0;
   int          n_mismatched = 0;
   logic [7:0]  sb_q[$];
   logic [7:0]  mon_exp;

   always #5 sim_clock = ~sim_clock;

   ahb_console_fifo #(.ADDR_WIDTH(12), .FIFO_AW(2), .WAIT_STATES(0)) u_dut0 (
      .HCLK(sim_clock), .HRESETn(power_on_reset_n), .HSEL(hsel0), .HADDR(haddr),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
      .HREADY(hreadyout0), .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0),
      .tty_valid(tty_valid0), .tty_data(tty_data0), .tty_ready(tty_ready),
      .stop_req(stop_req0), .stop_code(stop_code0)
   );

   ahb_console_fifo #(.ADDR_WIDTH(12), .FIFO_AW(2), .WAIT_STATES(3)) u_dut1 (
      .HCLK(sim_clock), .HRESETn(power_on_reset_n), .HSEL(hsel1), .HADDR(haddr),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
      .HREADY(hreadyout1), .HRDATA(hrdata1), .HREADYOUT(hreadyout1), .HRESP(hresp1),
      .tty_valid(tty_valid1), .tty_data(tty_data1), .tty_ready(tty_ready),
      .stop_req(stop_req1), .stop_code(stop_code1)
   );

   // Stream scoreboard: each byte accepted by the consumer must match the queue head.
   always @(negedge sim_clock) begin
      if (power_on_reset_n && tty_valid0 && tty_ready) begin
         n_compared++;
         if (sb_q.size() == 0) begin
            n_mismatched++;
            $display("FAIL stream: got byte %h, want no byte (queue empty)", tty_data0);
         end else begin
            mon_exp = sb_q.pop_front();
            if (tty_data0 !== mon_exp) begin
               n_mismatched++;
               $display("FAIL stream: got byte %h, want %h", tty_data0, mon_exp);
            end
         end
      end
   end

   task automatic ahb_xfer(input int tgt, input logic [11:0] addr, input logic wr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output int waits, output logic resp_first, output logic resp_last);
      hsel0  = (tgt == 0);
      hsel1  = (tgt == 1);
      haddr  = addr;
      htrans = 2'b10;
      hwrite = wr;
      @(posedge sim_clock); #1;
      hsel0  = 1'b0;
      hsel1  = 1'b0;
      htrans = 2'b00;
      hwdata = wdata;
      waits  = 0;
      @(negedge sim_clock);
      resp_first = (tgt == 0) ? hresp0 : hresp1;
      while (!((tgt == 0) ? hreadyout0 : hreadyout1) && waits < 64) begin
         waits++;
         @(negedge sim_clock);
      end
      rdata     = (tgt == 0) ? hrdata0 : hrdata1;
      resp_last = (tgt == 0) ? hresp0 : hresp1;
      @(posedge sim_clock); #1;
   endtask

   task automatic ahb_write(input int tgt, input logic [11:0] addr, input logic [31:0] wdata,
                            output int waits);
      logic [31:0] rd;
      logic        r1, r2;
      ahb_xfer(tgt, addr, 1'b1, wdata, rd, waits, r1, r2);
   endtask

   task automatic ahb_read(input int tgt, input logic [11:0] addr, output logic [31:0] rdata,
                           output int waits);
      logic r1, r2;
      ahb_xfer(tgt, addr, 1'b0, 32'd0, rdata, waits, r1, r2);
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      int          w;
      power_on_reset_n = 1'b0;
      hsel0 = 1'b0; hsel1 = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
      hsize = 3'd2; hwdata = '0; tty_ready = 1'b0;
      repeat (3) @(posedge sim_clock);
      #1;
      n_compared++;
      if ({hreadyout0, hresp0, hrdata0, tty_valid0} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
         n_mismatched++;
         $display("FAIL reset_bus: got rdy/resp/rdata/valid %b %b %h %b, want 1 0 0 0",
                  hreadyout0, hresp0, hrdata0, tty_valid0);
      end
      n_compared++;
      if ({stop_req0, stop_code0} !== 9'd0) begin
         n_mismatched++;
         $display("FAIL reset_stop: got %b %h, want 0 00", stop_req0, stop_code0);
      end
      @(posedge sim_clock); #1;
      power_on_reset_n = 1'b1;
      @(posedge sim_clock); #1;
      ahb_read(0, c_A_CTRL, rd, w);
      n_compared++;
      if (rd !== 32'd0) begin
         n_mismatched++;
         $display("FAIL reset_ctrl: got %h, want 00000000", rd);
      end
   endtask

   task automatic test_stream();
      logic [31:0] rd;
      int          w;
      tty_ready = 1'b1;
      sb_q.push_back(8'h41);
      ahb_write(0, c_A_DATA, 32'h0000_0041, w);
      sb_q.push_back(8'h42);
      ahb_write(0, c_A_DATA, 32'h0000_0042, w);
      n_compared++;
      if (w !== 0) begin
         n_mismatched++;
         $display("FAIL stream_write_waits: got %0d, want 0", w);
      end
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge sim_clock);
      #1;
      n_compared++;
      if (sb_q.size() != 0) begin
         n_mismatched++;
         $display("FAIL stream_drain: got %0d bytes left, want 0", sb_q.size());
      end
      ahb_read(0, c_A_STATUS, rd, w);
      n_compared++;
      if (rd !== 32'h0000_0000) begin
         n_mismatched++;
         $display("FAIL stream_status: got %h, want 00000000", rd);
      end
   endtask

   task automatic test_stall();
      logic [31:0] rd;
      int          w;
      tty_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back(8'(8'h10 + i));
         ahb_write(0, c_A_DATA, 32'h10 + i, w);
      end
      sb_q.push_back(8'h14);
      fork
         ahb_write(0, c_A_DATA, 32'h14, w);
         begin
            repeat (5) @(posedge sim_clock);
            #1 tty_ready = 1'b1;
            @(posedge sim_clock);
            #1 tty_ready = 1'b0;
         end
      join
      n_compared++;
      if (w !== 4) begin
         n_mismatched++;
         $display("FAIL stall_waits: got %0d low cycles, want 4", w);
      end
      ahb_read(0, c_A_STATUS, rd, w);
      n_compared++;
      if (rd !== 32'h0000_0104) begin
         n_mismatched++;
         $display("FAIL stall_status: got %h, want 00000104", rd);
      end
   endtask

   task automatic test_drop();
      logic [31:0] rd;
      int          w;
      ahb_write(0, c_A_CTRL, 32'h1, w);
      ahb_write(0, c_A_DATA, 32'h55, w);
      n_compared++;
      if (w !== 0) begin
         n_mismatched++;
         $display("FAIL drop_waits: got %0d, want 0", w);
      end
      ahb_read(0, c_A_STATUS, rd, w);
      n_compared++;
      if (rd !== 32'h0000_0304) begin
         n_mismatched++;
         $display("FAIL drop_status_ovf: got %h, want 00000304", rd);
      end
      ahb_write(0, c_A_STATUS, 32'h200, w);
      ahb_read(0, c_A_STATUS, rd, w);
      n_compared++;
      if (rd !== 32'h0000_0104) begin
         n_mismatched++;
         $display("FAIL drop_ovf_clear: got %h, want 00000104", rd);
      end
      tty_ready = 1'b1;
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge sim_clock);
      repeat (4) @(posedge sim_clock);
      #1;
      n_compared++;
      if (tty_valid0 !== 1'b0 || sb_q.size() != 0) begin
         n_mismatched++;
         $display("FAIL drop_drain: got valid %b left %0d, want 0 0", tty_valid0, sb_q.size());
      end
   endtask

   task automatic test_error();
      logic [31:0] rd;
      int          w;
      logic        rf, rl;
      ahb_xfer(0, 12'h010, 1'b0, 32'd0, rd, w, rf, rl);
      n_compared++;
      if ({w, rf, rl, rd} !== {32'd1, 1'b1, 1'b1, 32'd0}) begin
         n_mismatched++;
         $display("FAIL err_read: got waits %0d resp %b%b rdata %h, want 1 11 00000000", w, rf, rl, rd);
      end
      ahb_xfer(0, 12'h014, 1'b1, 32'h99, rd, w, rf, rl);
      n_compared++;
      if ({w, rf, rl} !== {32'd1, 1'b1, 1'b1}) begin
         n_mismatched++;
         $display("FAIL err_write: got waits %0d resp %b%b, want 1 11", w, rf, rl);
      end
      ahb_read(0, c_A_STATUS, rd, w);
      n_compared++;
      if (rd !== 32'd0 || tty_valid0 !== 1'b0) begin
         n_mismatched++;
         $display("FAIL err_fifo_unchanged: got status %h valid %b, want 00000000 0", rd, tty_valid0);
      end
      ahb_read(0, c_A_CTRL, rd, w);
      n_compared++;
      if (rd !== 32'h1) begin
         n_mismatched++;
         $display("FAIL err_ctrl_unchanged: got %h, want 00000001", rd);
      end
   endtask

   task automatic test_back_to_back();
      tty_ready = 1'b1;
      sb_q.push_back(8'h61);
      hsel0 = 1'b1; haddr = c_A_DATA; htrans = 2'b10; hwrite = 1'b1;
      @(posedge sim_clock); #1;
      haddr = c_A_CTRL; hwrite = 1'b1; hwdata = 32'h61;
      @(negedge sim_clock);
      n_compared++;
      if (hreadyout0 !== 1'b1) begin
         n_mismatched++;
         $display("FAIL b2b_ready1: got %b, want 1", hreadyout0);
      end
      @(posedge sim_clock); #1;
      haddr = c_A_CTRL; hwrite = 1'b0; hwdata = 32'h0;
      @(posedge sim_clock); #1;
      hsel0 = 1'b0; htrans = 2'b00;
      @(negedge sim_clock);
      n_compared++;
      if ({hreadyout0, hrdata0} !== {1'b1, 32'd0}) begin
         n_mismatched++;
         $display("FAIL b2b_ctrl_read: got rdy %b rdata %h, want 1 00000000", hreadyout0, hrdata0);
      end
      @(posedge sim_clock); #1;
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge sim_clock);
      #1;
      n_compared++;
      if (sb_q.size() != 0) begin
         n_mismatched++;
         $display("FAIL b2b_drain: got %0d bytes left, want 0", sb_q.size());
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] rd;
      int          w;
      ahb_read(1, c_A_STATUS, rd, w);
      n_compared++;
      if (w !== 3 || rd !== 32'd0) begin
         n_mismatched++;
         $display("FAIL ws_read: got waits %0d rdata %h, want 3 00000000", w, rd);
      end
      n_compared++;
      if (stop_req1 !== 1'b0) begin
         n_mismatched++;
         $display("FAIL ws_stop_before: got %b, want 0", stop_req1);
      end
      ahb_write(1, c_A_EXIT, 32'h07, w);
      n_compared++;
      if (w !== 3 || {stop_req1, stop_code1} !== {1'b1, 8'h07}) begin
         n_mismatched++;
         $display("FAIL ws_exit: got waits %0d stop %b code %h, want 3 1 07", w, stop_req1, stop_code1);
      end
      ahb_read(1, c_A_EXIT, rd, w);
      n_compared++;
      if (rd !== 32'h7 || stop_req1 !== 1'b1 || stop_req0 !== 1'b0) begin
         n_mismatched++;
         $display("FAIL ws_exit_read: got %h stop1 %b stop0 %b, want 00000007 1 0", rd, stop_req1, stop_req0);
      end
   endtask

   task automatic test_reset_in_stall();
      logic [31:0] rd;
      int          w;
      tty_ready = 1'b0;
      ahb_write(0, c_A_CTRL, 32'h0, w);
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back(8'(8'h20 + i));
         ahb_write(0, c_A_DATA, 32'h20 + i, w);
      end
      fork
         ahb_write(0, c_A_DATA, 32'h24, w);
         begin
            repeat (3) @(posedge sim_clock);
            #2;
            n_compared++;
            if (hreadyout0 !== 1'b0) begin
               n_mismatched++;
               $display("FAIL rst_stall_entered: got rdy %b, want 0", hreadyout0);
            end
            power_on_reset_n = 1'b0;
            #1;
            n_compared++;
            if ({hreadyout0, tty_valid0, hresp0} !== 3'b100) begin
               n_mismatched++;
               $display("FAIL rst_async: got rdy/valid/resp %b%b%b, want 100", hreadyout0, tty_valid0, hresp0);
            end
            sb_q.delete();
            @(posedge sim_clock); #1;
            power_on_reset_n = 1'b1;
         end
      join
      ahb_read(0, c_A_STATUS, rd, w);
      n_compared++;
      if (rd !== 32'd0) begin
         n_mismatched++;
         $display("FAIL rst_status: got %h, want 00000000", rd);
      end
      n_compared++;
      if ({stop_req1, stop_code1} !== 9'd0) begin
         n_mismatched++;
         $display("FAIL rst_stop_cleared: got %b %h, want 0 00", stop_req1, stop_code1);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_drop();
      test_error();
      test_back_to_back();
      test_wait_states();
      test_reset_in_stall();
      repeat (3) @(posedge sim_clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

`default_nettype wire
